// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destinations after ID and stalls
// ID when a source is not yet available, counting stall cycles.
module hazard_scoreboard #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_forward,
    input  logic              id_valid,
    input  logic              single_source,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic [ADDR_W-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic              mem_stall,
    input  logic              flush,
    input  logic              stat_clr,
    output logic              hazard_detected,
    output logic [CNT_W-1:0]  stall_count
);

    logic [DEPTH-1:0]  v_q, v_d;
    logic [DEPTH-1:0]  wb_q, wb_d;
    logic [DEPTH-1:0]  ld_q, ld_d;
    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [ADDR_W-1:0] dest_d [DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DEPTH-1:0]  match1, match2;
    logic              hit;

    always_comb begin
        match1 = '0;
        match2 = '0;
        hit    = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match1[i] = v_q[i] && wb_q[i] && (dest_q[i] == src1) && (dest_q[i] != '0);
            match2[i] = v_q[i] && wb_q[i] && (dest_q[i] == src2) && (dest_q[i] != '0)
                        && !single_source;
            // Forwarding hides everything except loads still inside the load-latency window
            if (match1[i] || match2[i]) begin
                if (!is_forward || ((i < LOAD_LAT) && ld_q[i])) begin
                    hit = 1'b1;
                end
            end
        end
        hazard_detected = hit && id_valid && !flush;
    end

    always_comb begin
        v_d  = v_q;
        wb_d = wb_q;
        ld_d = ld_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            dest_d[i] = dest_q[i];
        end
        if (!mem_stall) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                v_d[i]    = v_q[i-1];
                wb_d[i]   = wb_q[i-1];
                ld_d[i]   = ld_q[i-1];
                dest_d[i] = dest_q[i-1];
            end
            if (id_valid && !hazard_detected && !flush) begin
                v_d[0]    = 1'b1;
                wb_d[0]   = id_wb_en;
                ld_d[0]   = id_mem_read;
                dest_d[0] = id_dest;
            end else begin
                v_d[0]    = 1'b0;
                wb_d[0]   = 1'b0;
                ld_d[0]   = 1'b0;
                dest_d[0] = '0;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr) begin
            cnt_d = '0;
        end else if (hazard_detected && !mem_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q   <= '0;
            wb_q  <= '0;
            ld_q  <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
            end
        end else begin
            v_q   <= v_d;
            wb_q  <= wb_d;
            ld_q  <= ld_d;
            cnt_q <= cnt_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dest_q[i] <= dest_d[i];
            end
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table plus hand-written
// stall, reset and saturation sequences.
module tb_hazard_scoreboard;

    typedef struct {
        logic       rstn;
        logic       fwd;
        logic       vld;
        logic       ss;
        logic [4:0] s1;
        logic [4:0] s2;
        logic [4:0] dst;
        logic       wb;
        logic       ld;
        logic       ms;
        logic       fl;
        logic       clr;
        logic       eh;
        int         ec;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        is_forward, id_valid, single_source;
    logic [4:0]  src1, src2, id_dest;
    logic        id_wb_en, id_mem_read, mem_stall, flush, stat_clr;
    logic        hazard_detected;
    logic [15:0] stall_count;
    logic        hazard_sat;
    logic [3:0]  count_sat;

    int total;
    int bad;

    hazard_scoreboard u_dut (
        .clk(clk), .rst(rst), .is_forward(is_forward), .id_valid(id_valid),
        .single_source(single_source), .src1(src1), .src2(src2), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .mem_stall(mem_stall),
        .flush(flush), .stat_clr(stat_clr), .hazard_detected(hazard_detected),
        .stall_count(stall_count)
    );

    hazard_scoreboard #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .is_forward(is_forward), .id_valid(id_valid),
        .single_source(single_source), .src1(src1), .src2(src2), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .mem_stall(mem_stall),
        .flush(flush), .stat_clr(stat_clr), .hazard_detected(hazard_sat),
        .stall_count(count_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic rstn, fwd, vld, ss,
                                input logic [4:0] s1, s2, dst,
                                input logic wb, ld, ms, fl, clr, eh,
                                input int ec);
        vec_t v;
        v.rstn = rstn; v.fwd = fwd; v.vld = vld; v.ss = ss;
        v.s1 = s1; v.s2 = s2; v.dst = dst; v.wb = wb; v.ld = ld;
        v.ms = ms; v.fl = fl; v.clr = clr; v.eh = eh; v.ec = ec;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst           = v.rstn;
        is_forward    = v.fwd;
        id_valid      = v.vld;
        single_source = v.ss;
        src1          = v.s1;
        src2          = v.s2;
        id_dest       = v.dst;
        id_wb_en      = v.wb;
        id_mem_read   = v.ld;
        mem_stall     = v.ms;
        flush         = v.fl;
        stat_clr      = v.clr;
    endtask

    task automatic run(input string name, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check({name, ".hazard"}, int'(hazard_detected), int'(v.eh));
        @(posedge clk);
        #1;
        check({name, ".count"}, int'(stall_count), v.ec);
    endtask

    vec_t tbl [27];
    vec_t hz;

    initial begin
        total = 0;
        bad   = 0;
        drive(mk(0,0,0,1,0,0,0,0,0,0,0,0,0,0));

        tbl[0]  = mk(0,0,1,1,3,0,0,0,0,0,0,0, 0,0);
        tbl[1]  = mk(1,0,1,1,0,0,3,1,0,0,0,0, 0,0);
        tbl[2]  = mk(1,0,1,0,3,0,0,0,0,0,0,0, 1,1);
        tbl[3]  = mk(1,0,1,0,3,0,0,0,0,0,0,0, 1,2);
        tbl[4]  = mk(1,0,1,0,3,0,0,0,0,0,0,0, 0,2);
        tbl[5]  = mk(1,0,1,1,0,0,0,1,0,0,0,0, 0,2);
        tbl[6]  = mk(1,0,1,1,0,0,0,0,0,0,0,0, 0,2);
        tbl[7]  = mk(1,1,1,1,0,0,0,1,1,0,0,0, 0,2);
        tbl[8]  = mk(1,1,1,1,0,0,0,0,0,0,0,0, 0,2);
        tbl[9]  = mk(1,1,1,1,0,0,5,1,1,0,0,0, 0,2);
        tbl[10] = mk(1,1,1,0,1,5,0,0,0,0,0,0, 1,3);
        tbl[11] = mk(1,1,1,0,1,5,0,0,0,0,0,0, 0,3);
        tbl[12] = mk(1,1,1,1,0,0,5,1,1,0,0,0, 0,3);
        tbl[13] = mk(1,1,1,1,7,5,0,0,0,0,0,0, 0,3);
        tbl[14] = mk(1,1,1,1,0,0,6,1,0,0,0,0, 0,3);
        tbl[15] = mk(1,1,1,1,6,0,0,0,0,0,0,0, 0,3);
        tbl[16] = mk(1,0,1,1,6,0,0,0,0,0,0,0, 1,4);
        tbl[17] = mk(1,0,1,1,6,0,0,0,0,0,0,0, 0,4);
        tbl[18] = mk(1,0,1,1,0,0,8,1,0,0,0,0, 0,4);
        tbl[19] = mk(1,0,1,1,8,0,0,0,0,0,1,0, 0,4);
        tbl[20] = mk(1,0,1,1,8,0,0,0,0,0,0,0, 1,5);
        tbl[21] = mk(1,0,1,1,8,0,0,0,0,0,0,0, 0,5);
        tbl[22] = mk(1,0,1,1,0,0,9,1,0,0,0,0, 0,5);
        tbl[23] = mk(1,0,0,1,9,0,0,0,0,0,0,0, 0,5);
        tbl[24] = mk(1,0,1,1,9,0,0,0,0,0,0,0, 1,6);
        tbl[25] = mk(1,0,1,1,9,0,0,0,0,0,0,0, 0,6);
        tbl[26] = mk(1,0,0,1,0,0,0,0,0,0,0,1, 0,0);

        for (int i = 0; i < 27; i++) begin
            run($sformatf("vec%0d", i), tbl[i]);
        end

        // Memory stall freezes entries and the counter, even with flush asserted
        run("ms.rst",   mk(0,0,0,1,0,0,0,0,0,0,0,0, 0,0));
        run("ms.issue", mk(1,0,1,1,0,0,3,1,0,0,0,0, 0,0));
        run("ms.hold0", mk(1,0,1,1,3,0,0,0,0,1,0,0, 1,0));
        run("ms.hold1", mk(1,0,1,1,3,0,0,0,0,1,1,0, 0,0));
        run("ms.hold2", mk(1,0,1,1,3,0,0,0,0,1,0,0, 1,0));
        run("ms.go0",   mk(1,0,1,1,3,0,0,0,0,0,0,0, 1,1));
        run("ms.go1",   mk(1,0,1,1,3,0,0,0,0,0,0,0, 1,2));
        run("ms.done",  mk(1,0,1,1,3,0,0,0,0,0,0,0, 0,2));

        // Asynchronous reset in the middle of a hazard cycle
        run("ar.issue", mk(1,0,1,1,0,0,3,1,0,0,0,0, 0,2));
        @(negedge clk);
        drive(mk(1,0,1,1,3,0,0,0,0,0,0,0, 1,2));
        #1;
        check("ar.pre_hazard", int'(hazard_detected), 1);
        #2;
        rst = 1'b0;
        #1;
        check("ar.hazard", int'(hazard_detected), 0);
        check("ar.count", int'(stall_count), 0);
        #1;
        rst = 1'b1;
        run("ar.after", mk(1,0,1,1,3,0,0,0,0,0,0,0, 0,0));

        // Saturation on the 4-bit counter instance
        run("sat.rst", mk(0,0,0,1,0,0,0,0,0,0,0,0, 0,0));
        check("sat.rst_count", int'(count_sat), 0);
        hz = mk(1,0,1,1,3,0,0,0,0,0,0,0, 1,0);
        for (int r = 1; r <= 10; r++) begin
            run($sformatf("sat.issue%0d", r), mk(1,0,1,1,0,0,3,1,0,0,0,0, 0,2*(r-1)));
            hz.ec = 2*r - 1;
            run($sformatf("sat.a%0d", r), hz);
            hz.ec = 2*r;
            run($sformatf("sat.b%0d", r), hz);
            check($sformatf("sat.count%0d", r), int'(count_sat), (2*r > 15) ? 15 : 2*r);
        end
        run("sat.issue_clr", mk(1,0,1,1,0,0,3,1,0,0,0,0, 0,20));
        check("sat.full", int'(count_sat), 15);
        run("sat.clr", mk(1,0,1,1,3,0,0,0,0,0,0,1, 1,0));
        check("sat.cleared", int'(count_sat), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width.
REQ-002 SHALL have parameter DEPTH, default 2, number of tracked in-flight stages after ID (entry 0 = EXE); legal range 1..8.
REQ-003 SHALL have parameter LOAD_LAT, default 1, number of stages (from entry 0) in which a load result is not yet forwardable; legal range 1..DEPTH.
REQ-004 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port is_forward  input  1  1 = forwarding mode, 0 = no-forwarding mode.
REQ-008 SHALL have port id_valid  input  1  valid instruction in ID.
REQ-009 SHALL have port single_source  input  1  ID instruction reads src1 only.
REQ-010 SHALL have ports src1, src2  input  ADDR_W  ID source registers.
REQ-011 SHALL have port id_dest  input  ADDR_W  ID destination register.
REQ-012 SHALL have port id_wb_en  input  1  ID instruction writes back.
REQ-013 SHALL have port id_mem_read  input  1  ID instruction is a load.
REQ-014 SHALL have port mem_stall  input  1  pipeline frozen by memory.
REQ-015 SHALL have port flush  input  1  ID instruction squashed (branch taken).
REQ-016 SHALL have port stat_clr  input  1  synchronous clear of stall_count.
REQ-017 SHALL have port hazard_detected  output  1  stall ID/IF this cycle.
REQ-018 SHALL have port stall_count  output  CNT_W  saturating count of hazard stall cycles.

Function
REQ-019 SHALL hold DEPTH entries {v, dest, wb, ld}, registered.
REQ-020 When mem_stall=0, each rising edge SHALL shift entry[i-1] into entry[i] for i=1..DEPTH-1; the oldest entry drops.
REQ-021 When mem_stall=0, entry[0] SHALL load {1, id_dest, id_wb_en, id_mem_read} if id_valid=1, hazard_detected=0 and flush=0; otherwise a bubble (v=0).
REQ-022 When mem_stall=1, all entries SHALL hold unchanged, regardless of flush or id_valid.
REQ-023 match(i,s) SHALL be v[i] && wb[i] && dest[i]==s && dest[i]!=0.
REQ-024 src2 SHALL be ignored when single_source=1.
REQ-025 Non-forward mode: hazard_detected SHALL be 1 iff id_valid=1, flush=0 and match(i,src) for any i in 0..DEPTH-1 and any used source.
REQ-026 Forward mode: hazard_detected SHALL be 1 iff id_valid=1, flush=0 and match(i,src) && ld[i] for any i in 0..LOAD_LAT-1 and any used source.
REQ-027 hazard_detected SHALL be combinational from current entries and ID inputs (same-cycle response).
REQ-028 is_forward SHALL take effect in the same cycle it changes; entries are not modified by mode changes.
REQ-029 stall_count SHALL increment by 1 on each edge where hazard_detected=1 and mem_stall=0, saturating at 2^CNT_W-1.
REQ-030 stat_clr=1 SHALL zero stall_count on the next edge and take priority over increment.

Reset
REQ-031 rst=0 SHALL immediately clear all entry v bits, dest/wb/ld to 0, and stall_count to 0, independent of clk.
REQ-032 With rst=0, hazard_detected SHALL read 0; the first edge after rst deasserts behaves per REQ-020..REQ-030.

Verification
REQ-033 Non-forward, defaults: issue dest=3 wb=1; next cycle ID src1=3 -> hazard_detected=1 for exactly 2 cycles, 0 on 3rd, stall_count=2.
REQ-034 Forward: issue load dest=5; next cycle ID src2=5, single_source=0 -> hazard 1 for exactly 1 cycle; repeat with single_source=1, src1=7 -> hazard 0.
REQ-035 Issue dest=0 wb=1, then ID src1=0, both modes -> hazard_detected stays 0, stall_count stays 0.
REQ-036 During REQ-033 hazard, mem_stall=1 for 3 cycles -> hazard held at 1, entries unchanged, stall_count unchanged; resumes counting after release (total 2).
REQ-037 rst pulsed low mid-cycle with entry[0] valid and hazard=1 -> hazard_detected and stall_count go 0 before next edge; ID src1=3 after release -> no hazard.
REQ-038 CNT_W=4, hold a hazard for 20 unstalled cycles -> stall_count=15; stat_clr=1 together with hazard -> 0 next edge.
